// File: rtl/fetch_pc_gen_if.sv
// Bundle of the fetch stage's backend, BTB-update, instruction-memory and decode-queue signals.
// master = fetch stage, slave = surrounding environment.
interface fetch_pc_gen_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  modport master (
    input  redirect_valid, redirect_pc, btb_upd_valid, btb_upd_pc, btb_upd_target,
    input  imem_resp, imem_rdata, out_ready,
    output imem_addr, imem_rmask, out_valid, out_pc, out_inst, out_pred_taken, out_pred_target
  );

  modport slave (
    output redirect_valid, redirect_pc, btb_upd_valid, btb_upd_pc, btb_upd_target,
    output imem_resp, imem_rdata, out_ready,
    input  imem_addr, imem_rmask, out_valid, out_pc, out_inst, out_pred_taken, out_pred_target
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// First fetch stage: PC generation, one outstanding imem read with epoch-based stale drop,
// and a decode queue. Optional direct-mapped BTB when FETCH_BTB_EN is defined.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h6000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_pc_gen_if.master    bus,
  output logic [1:0]        o_dbg_state
);
  localparam int QW  = $clog2(QUEUE_DEPTH);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;
  localparam logic [QW:0]   FULL_C  = (QW+1)'(QUEUE_DEPTH);
  localparam logic [QW:0]   CNT_ONE = (QW+1)'(1);
  localparam logic [QW-1:0] PTR_ONE = QW'(1);

  // S_STALE: a read is still outstanding but its epoch was killed by a redirect.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_STALE = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]   r_pc, r_req_addr, r_req_target;
  logic          r_req_taken;
  logic [31:0]   w_pred_next;
  logic          w_pred_taken;
  logic          w_issue, w_push, w_pop, w_nonempty;
  logic [QW:0]   r_count;
  logic [QW-1:0] r_head, r_tail;
  logic [31:0]   r_q_pc   [QUEUE_DEPTH];
  logic [31:0]   r_q_inst [QUEUE_DEPTH];
  logic [31:0]   r_q_tgt  [QUEUE_DEPTH];
  logic          r_q_tk   [QUEUE_DEPTH];

`ifdef FETCH_BTB_EN
  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
  logic [31:0]            r_btb_tgt [BTB_ENTRIES];
  logic [IDX-1:0]         w_lk_idx, w_up_idx;
  logic                   w_unused_btb;

  assign w_lk_idx     = r_pc[2 +: IDX];
  assign w_up_idx     = bus.btb_upd_pc[2 +: IDX];
  assign w_unused_btb = ^bus.btb_upd_pc[1:0];
  // Lookup reads registers, so a same-cycle update is seen only from the next cycle.
  assign w_pred_taken = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == r_pc[31:2+IDX]);
  assign w_pred_next  = w_pred_taken ? r_btb_tgt[w_lk_idx] : r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btb_valid <= '0;
    end else if (bus.btb_upd_valid) begin
      r_btb_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.btb_upd_valid) begin
      r_btb_tag[w_up_idx] <= bus.btb_upd_pc[31:2+IDX];
      r_btb_tgt[w_up_idx] <= bus.btb_upd_target;
    end
  end
`else
  logic w_unused_btb;
  assign w_unused_btb = ^{bus.btb_upd_valid, bus.btb_upd_pc, bus.btb_upd_target};
  assign w_pred_taken = 1'b0;
  assign w_pred_next  = r_pc + 32'd4;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!rst && !bus.redirect_valid && (r_count < FULL_C)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (bus.imem_resp) begin
          w_push      = !bus.redirect_valid;
          w_state_nxt = S_IDLE;
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_STALE;
        end
      end
      S_STALE: begin
        if (bus.imem_resp) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign o_dbg_state    = r_state;
  assign bus.imem_rmask = (!rst && (w_issue || r_state != S_IDLE)) ? 4'b1111 : 4'b0000;
  assign bus.imem_addr  = (r_state == S_IDLE) ? r_pc : r_req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_req_taken  <= 1'b0;
      r_req_target <= '0;
    end else if (bus.redirect_valid) begin
      r_pc <= bus.redirect_pc;
    end else if (w_issue) begin
      r_req_addr   <= r_pc;
      r_req_taken  <= w_pred_taken;
      r_req_target <= w_pred_next;
      r_pc         <= w_pred_next;
    end
  end

  // Decode side is valid/ready: an entry moves only in a cycle where out_valid && out_ready.
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && bus.out_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_pc[r_tail]   <= r_req_addr;
      r_q_inst[r_tail] <= bus.imem_rdata;
      r_q_tk[r_tail]   <= r_req_taken;
      r_q_tgt[r_tail]  <= r_req_target;
    end
  end

  assign bus.out_valid       = w_nonempty;
  assign bus.out_pc          = w_nonempty ? r_q_pc[r_head]   : '0;
  assign bus.out_inst        = w_nonempty ? r_q_inst[r_head] : '0;
  assign bus.out_pred_taken  = w_nonempty ? r_q_tk[r_head]   : 1'b0;
  assign bus.out_pred_target = w_nonempty ? r_q_tgt[r_head]  : '0;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomised bench for fetch_pc_gen: a memory/backend driver, a fetch-stream reference model
// feeding an expected queue, and a monitor that checks every decode handshake.
module tb_fetch_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h6000_0000;
  localparam int DEPTH = 4;
  localparam int BTB_N = 16;
  localparam int W     = 97;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  fetch_pc_gen_if bus();

  fetch_pc_gen #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH), .BTB_ENTRIES(BTB_N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_pops = 0;
  logic mon_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc = RESET_PC;
  logic        m_infl = 1'b0;
  logic        m_stale = 1'b0;
  logic [W-1:0] m_ent;
  logic        btb_v   [BTB_N];
  logic [31:0] btb_pc  [BTB_N];
  logic [31:0] btb_tgt [BTB_N];
  logic        rst_q = 1'b1;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % BTB_N);
  endfunction

  task automatic predict(input logic [31:0] pc, output logic tk, output logic [31:0] nx);
    tk = 1'b0;
    nx = pc + 32'd4;
`ifdef FETCH_BTB_EN
    if (btb_v[idx_of(pc)] && ((btb_pc[idx_of(pc)] >> 2) == (pc >> 2))) begin
      tk = 1'b1;
      nx = btb_tgt[idx_of(pc)];
    end
`endif
  endtask

  always @(negedge clk) begin : model
    int   occ;
    logic exp_req, infl0, tk;
    logic [31:0] nx;
    #1;
    if (rst) begin
      if (rst_q) begin
        check("rst_rmask",  {28'b0, bus.imem_rmask}, 32'h0);
        check("rst_addr",   bus.imem_addr, RESET_PC);
        check("rst_valid",  {31'b0, bus.out_valid}, 32'h0);
        check("rst_pc",     bus.out_pc, 32'h0);
        check("rst_inst",   bus.out_inst, 32'h0);
        check("rst_taken",  {31'b0, bus.out_pred_taken}, 32'h0);
        check("rst_target", bus.out_pred_target, 32'h0);
        check("rst_state",  {30'b0, dbg_state}, 32'h0);
      end
      exp_q.delete();
      m_pc    = RESET_PC;
      m_infl  = 1'b0;
      m_stale = 1'b0;
      for (int i = 0; i < BTB_N; i++) btb_v[i] = 1'b0;
    end else begin
      occ     = exp_q.size() + (mon_pop ? 1 : 0);
      infl0   = m_infl;
      exp_req = infl0 || (!bus.redirect_valid && occ < DEPTH);
      check("imem_rmask", {28'b0, bus.imem_rmask}, exp_req ? 32'hF : 32'h0);
      if (exp_req) check("imem_addr", bus.imem_addr, infl0 ? m_ent[96:65] : m_pc);
      if (bus.imem_resp && infl0) begin
        if (!m_stale && !bus.redirect_valid) exp_q.push_back(m_ent);
        m_infl  = 1'b0;
        m_stale = 1'b0;
      end
      if (!infl0 && exp_req) begin
        predict(m_pc, tk, nx);
        m_ent   = {m_pc, inst_of(m_pc), tk, nx};
        m_infl  = 1'b1;
        m_stale = 1'b0;
        m_pc    = nx;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        m_pc = bus.redirect_pc;
        if (m_infl) m_stale = 1'b1;
      end
      if (bus.btb_upd_valid) begin
        btb_v[idx_of(bus.btb_upd_pc)]   = 1'b1;
        btb_pc[idx_of(bus.btb_upd_pc)]  = bus.btb_upd_pc;
        btb_tgt[idx_of(bus.btb_upd_pc)] = bus.btb_upd_target;
      end
    end
    rst_q = rst;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    mon_pop = 1'b0;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      mon_pop = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pc %h expected no entry at %0t", bus.out_pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_pc",          bus.out_pc, e[96:65]);
        check("out_inst",        bus.out_inst, e[64:33]);
        check("out_pred_taken",  {31'b0, bus.out_pred_taken}, {31'b0, e[32]});
        check("out_pred_target", bus.out_pred_target, e[31:0]);
        n_pops++;
      end
    end
  end

  // ---------------- driver ----------------
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(3))
      0:       return 32'h6000_1000;
      1:       return 32'hFFFF_FFFC;
      default: return RESET_PC + ($urandom_range(63) << 2);
    endcase
  endfunction

  task automatic cycle_step(input bit do_rst, input int ready_pct, input int redir_pct,
                            input int max_lat, input bit extras);
    @(posedge clk);
    #1;
    rst                = do_rst;
    bus.imem_resp      = 1'b0;
    bus.imem_rdata     = $urandom;
    bus.redirect_valid = 1'b0;
    bus.btb_upd_valid  = 1'b0;
    bus.out_ready      = ($urandom_range(99) < ready_pct);
    if (do_rst) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = inst_of(mem_addr);
        mem_busy       = 1'b0;
      end
    end
    if (!do_rst && $urandom_range(99) < (bus.imem_resp ? 4 * redir_pct : redir_pct)) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pick_pc();
    end
    if (!do_rst && extras && $urandom_range(5) == 0) begin
      bus.btb_upd_valid  = 1'b1;
      bus.btb_upd_pc     = ($urandom_range(15) == 0) ? 32'hFFFF_FFF8 : RESET_PC + ($urandom_range(63) << 2);
      bus.btb_upd_target = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : RESET_PC + ($urandom_range(63) << 2);
    end
    #1;
    if (!do_rst && !bus.imem_resp) begin
      if (!mem_busy && bus.imem_rmask == 4'hF) begin
        mem_busy = 1'b1;
        mem_addr = bus.imem_addr;
        mem_cnt  = $urandom_range(max_lat, 1);
      end else if (extras && !mem_busy && bus.imem_rmask == 4'h0 && $urandom_range(15) == 0) begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hDEAD_0000 | $urandom_range(255);
      end
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.btb_upd_valid  = 1'b0;
    bus.btb_upd_pc     = '0;
    bus.btb_upd_target = '0;
    bus.imem_resp      = 1'b0;
    bus.imem_rdata     = '0;
    bus.out_ready      = 1'b0;

    repeat (3)    cycle_step(1'b1, 100, 0, 1, 1'b0);
    repeat (40)   cycle_step(1'b0, 100, 0, 1, 1'b0);  // steady stream, 1-cycle memory
    repeat (40)   cycle_step(1'b0, 0,   0, 1, 1'b0);  // decode stalled: queue fills
    repeat (20)   cycle_step(1'b0, 100, 0, 1, 1'b0);
    repeat (1200) cycle_step(1'b0, 70,  3, 3, 1'b1);
    repeat (3)    cycle_step(1'b1, 100, 0, 1, 1'b0);  // reset in the middle of traffic
    repeat (1200) cycle_step(1'b0, 50,  6, 2, 1'b1);
    repeat (40)   cycle_step(1'b0, 100, 0, 1, 1'b0);
    @(negedge clk);
    #2;
    n_cmp++;
    if (n_pops < 200) begin
      n_bad++;
      $display("FAIL output_count: got %0d entries expected at least 200", n_pops);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised first fetch stage. It generates the PC, issues one instruction-memory read at a time, and tags each read with a redirect epoch so stale responses are dropped. Predicts next-PC with an optional internal direct-mapped BTB and buffers fetched instructions in a ready/valid queue that feeds decode. It replaces the single-register fetch front with decoupled, flush-safe buffering.

## Interface
Parameters:
- RESET_PC, 32'h6000_0000, PC fetched first after reset
- QUEUE_DEPTH, 4, fetch-queue entries (power of 2, ≥2)
- BTB_ENTRIES, 16, BTB entries (power of 2, ≥2); IDX = log2(BTB_ENTRIES)

Ports:
- clk  in  1  clock; everything on posedge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  mispredict/flush from backend
- redirect_pc  in  32  correct target PC
- btb_upd_valid  in  1  write BTB entry
- btb_upd_pc  in  32  PC of taken branch
- btb_upd_target  in  32  its target
- imem_addr  out  32  read address
- imem_rmask  out  4  4'b1111 while request pending, else 0
- imem_resp  in  1  read data valid (one cycle)
- imem_rdata  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- out_pred_taken  out  1  head was predicted taken
- out_pred_target  out  32  head predicted next PC

## Operation
- State: pc, pending (request outstanding), stale (epoch mismatch), queue (count 0..QUEUE_DEPTH), BTB valid/tag/target arrays.
- Issue: when !pending && count + 0 < QUEUE_DEPTH (one slot reserved per in-flight read) and no redirect this cycle, assert imem_rmask=4'b1111, imem_addr=pc; set pending; latch pred for pc; pc ← predicted next-PC.
- While pending: imem_addr/imem_rmask held stable until imem_resp.
- Prediction: index pc[2+:IDX], tag pc[31:2+IDX]; valid && tag match → taken, next = target; else next = pc+4.
- Response: imem_resp clears pending; if !stale, push {addr, imem_rdata, pred_taken, pred_next}; if stale, drop and clear stale.
- Redirect: queue flushed (count←0), pc ← redirect_pc; if pending (and no imem_resp same cycle) set stale; a response arriving in the redirect cycle is dropped.
- Pop when out_valid && out_ready; simultaneous push and pop both occur, count unchanged.
- BTB update writes valid/tag/target at index of btb_upd_pc; lookup in the same cycle at the same index returns pre-update contents.
- PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset: pc=RESET_PC, pending=0, stale=0, count=0, all BTB valid=0; imem_rmask=0, imem_addr=RESET_PC, out_valid=0, out_* = 0.
- First request asserted the first cycle rst is low.
- Response at cycle t → out_valid earliest t+1 (registered queue, no bypass).
- Next request issued earliest t+1 after response at t; with 1-cycle memory, throughput 1 instr / 2 cycles.
- Redirect at cycle t: out_valid=0 at t+1; request to redirect_pc at t+1 if no read outstanding, else the cycle after the stale response.
- Full queue (count = QUEUE_DEPTH): no issue; never overflows; pop of empty queue ignored.
- rst mid-request: pending/stale cleared; a later imem_resp without pending is ignored.

## Configuration
- FETCH_BTB_EN defined: BTB present, prediction as above.
- Not defined: no BTB storage; btb_upd_* ignored; next-PC always pc+4; out_pred_taken=0, out_pred_target=pc+4.

## Test plan
- Reset, out_ready=1, 1-cycle memory returning 0x00000013 → out_pc sequence 0x60000000, 0x60000004, 0x60000008, one per 2 cycles.
- out_ready=0, QUEUE_DEPTH=4 → exactly 4 requests issued, then imem_rmask=0 until a pop; order preserved on release.
- Redirect to 0x60001000 while read of 0x60000008 pending → that response dropped, next out_pc = 0x60001000, no 0x60000008 entry.
- Redirect in same cycle as imem_resp → response dropped, out_valid=0 next cycle, next request to redirect_pc.
- FETCH_BTB_EN: update pc=0x60000004 → 0x60000100, then fetch → 0x60000004 entry has out_pred_taken=1, out_pred_target=0x60000100, next out_pc 0x60000100; without macro next out_pc 0x60000008.
- PC wrap: redirect to 0xFFFFFFFC → following out_pc = 0x00000000.
